// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state type, and the byte-lane helper functions used by the lane unit.
package mem_defs;

    // Access size encodings as driven by the core (2'b11 behaves as a word).
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_e;

    // Byte-lane enables for a store of the given size at byte offset 'offset'.
    // Only meaningful for aligned requests; misaligned ones never reach the SRAM.
    function automatic logic [3:0] be_decode(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Bring the addressed byte/half/word of an SRAM word down to bit 0 and
    // zero the bits above the access size. The core does the sign extension.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: result = {24'h00_0000, shifted[7:0]};
            SIZE_HALF: result = {16'h0000, shifted[15:0]};
            default:   result = shifted;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// Combinational byte-lane unit: positions store data and byte enables on the
// SRAM lanes, and aligns/masks load data coming back from the SRAM.
module dmem_lane_u
    import mem_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] sram_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    // Replicate sub-word store data across all lanes; the enables pick the lane.
    always_comb begin
        be        = be_decode(size, offset);
        load_data = load_align(sram_rdata, size, offset);
        case (size)
            SIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
            SIZE_HALF: lane_wdata = {2{wdata[15:0]}};
            default:   lane_wdata = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the core's MEM-stage bus and a word-organised
// synchronous SRAM. Latches each request, optionally inserts wait states,
// performs one SRAM cycle and acknowledges with ack_n low for one cycle.
module dmem_ctrl
    import mem_defs::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dad,
    input  logic              mreq,
    input  logic              write,
    input  logic [1:0]        size,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack_n,
    output logic              err,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_e            state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [1:0]        off_q,        off_d;
    logic              write_q,      write_d;
    logic [1:0]        size_q,       size_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic              bad_q,        bad_d;
    logic              err_q,        err_d;
    logic [31:0]       rdata_q,      rdata_d;
    logic              sram_cs_q,    sram_cs_d;
    logic              sram_we_q,    sram_we_d;
    logic [3:0]        sram_be_q,    sram_be_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [31:0]       sram_wdata_q, sram_wdata_d;

    // Request view: live bus in IDLE (so a zero-wait access can be set up on
    // the accepting edge), latched copy in every other state.
    logic              req_idle;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_off;
    logic              req_write;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;

    logic              misaligned;
    logic              out_of_range;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic [31:0]       load_result;

    // Select between the live bus and the latched request.
    always_comb begin
        req_idle  = (state_q == ST_IDLE);
        req_addr  = req_idle ? dad[ADDR_W+1:2] : addr_q;
        req_off   = req_idle ? dad[1:0]        : off_q;
        req_write = req_idle ? write           : write_q;
        req_size  = req_idle ? size            : size_q;
        req_wdata = req_idle ? wdata           : wdata_q;
    end

    // Classify the incoming request: misaligned half/word, or beyond the SRAM.
    always_comb begin
        misaligned   = ((size == SIZE_HALF) && dad[0]) ||
                       (size[1] && (dad[1:0] != 2'b00));
        out_of_range = ((dad >> (ADDR_W + 2)) != 32'd0);
    end

    dmem_lane_u u_lane (
        .size       (req_size),
        .offset     (req_off),
        .wdata      (req_wdata),
        .sram_rdata (sram_rdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    // Load result presented during DONE: SRAM data only arrives in that cycle,
    // so it is passed through while ack_n is low and captured for holding.
    always_comb begin
        load_result = bad_q ? 32'h0000_0000 : load_data;
    end

    // Next-state, request latch, wait counter and registered-output values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        off_d        = off_q;
        write_d      = write_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        bad_d        = bad_q;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        sram_cs_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_be_d    = 4'b0000;
        sram_addr_d  = '0;
        sram_wdata_d = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (mreq) begin
                    addr_d  = dad[ADDR_W+1:2];
                    off_d   = dad[1:0];
                    write_d = write;
                    size_d  = size;
                    wdata_d = wdata;
                    bad_d   = misaligned || out_of_range;
                    cnt_d   = 4'd0;
                    if (misaligned || out_of_range) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!write_q) begin
                    rdata_d = load_result;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SRAM strobes are registered so they are high for exactly the ACCESS cycle.
        if (state_d == ST_ACCESS) begin
            sram_cs_d    = 1'b1;
            sram_we_d    = req_write;
            sram_be_d    = req_write ? lane_be : 4'b1111;
            sram_addr_d  = req_addr;
            sram_wdata_d = req_write ? lane_wdata : 32'h0000_0000;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            off_q        <= 2'b00;
            write_q      <= 1'b0;
            size_q       <= SIZE_WORD;
            wdata_q      <= 32'h0000_0000;
            bad_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_be_q    <= 4'b0000;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            write_q      <= write_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            bad_q        <= bad_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_be_q    <= sram_be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // Bus-side outputs: ack_n mirrors mreq in IDLE so the core stalls at once.
    always_comb begin
        case (state_q)
            ST_IDLE: ack_n = mreq;
            ST_DONE: ack_n = 1'b0;
            default: ack_n = 1'b1;
        endcase
        rdata = ((state_q == ST_DONE) && !write_q) ? load_result : rdata_q;
    end

    assign err        = err_q;
    assign sram_cs    = sram_cs_q;
    assign sram_we    = sram_we_q;
    assign sram_be    = sram_be_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states and one with
// three, sharing a behavioural word-organised synchronous SRAM.
module tb_dmem_ctrl;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       dad;
    logic              write;
    logic [1:0]        size;
    logic [31:0]       wdata;
    logic              mreq0, mreq3;

    logic [31:0]       rdata0, rdata3;
    logic              ack0, ack3;
    logic              err0, err3;
    logic              cs0, cs3;
    logic              we0, we3;
    logic [3:0]        be0, be3;
    logic [ADDR_W-1:0] addr0, addr3;
    logic [31:0]       swd0, swd3;
    logic [31:0]       srd0, srd3;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              mem_init = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .dad(dad), .mreq(mreq0), .write(write),
        .size(size), .wdata(wdata), .rdata(rdata0), .ack_n(ack0), .err(err0),
        .sram_cs(cs0), .sram_we(we0), .sram_be(be0), .sram_addr(addr0),
        .sram_wdata(swd0), .sram_rdata(srd0)
    );

    dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .dad(dad), .mreq(mreq3), .write(write),
        .size(size), .wdata(wdata), .rdata(rdata3), .ack_n(ack3), .err(err3),
        .sram_cs(cs3), .sram_we(we3), .sram_be(be3), .sram_addr(addr3),
        .sram_wdata(swd3), .sram_rdata(srd3)
    );

    // Behavioural SRAM: writes honour byte enables, reads appear the cycle after cs.
    always @(posedge clk) begin
        if (!mem_init) begin
            mem[5]   <= 32'hDEAD_BEEF;
            mem[7]   <= 32'hCAFE_F00D;
            mem_init <= 1'b1;
        end
        if (cs0) begin
            if (we0) begin
                for (int i = 0; i < 4; i++)
                    if (be0[i]) mem[addr0][8*i +: 8] <= swd0[8*i +: 8];
            end else begin
                srd0 <= mem[addr0];
            end
        end
        if (cs3) begin
            if (we3) begin
                for (int j = 0; j < 4; j++)
                    if (be3[j]) mem[addr3][8*j +: 8] <= swd3[8*j +: 8];
            end else begin
                srd3 <= mem[addr3];
            end
        end
    end

    // Drive one request on the selected instance and follow it to its ack.
    // Call just after a rising edge; returns just after the edge leaving DONE.
    task automatic issue(input bit sel3, input logic [31:0] a, input logic wr,
                         input logic [1:0] sz, input logic [31:0] wd,
                         output int busy, output logic [31:0] rd, output logic er,
                         output int cs_seen, output logic [3:0] be_seen,
                         output logic [31:0] wd_seen, output logic we_seen);
        bit done;
        dad = a; write = wr; size = sz; wdata = wd;
        if (sel3) mreq3 = 1'b1; else mreq0 = 1'b1;
        busy = 0; cs_seen = 0; rd = '0; er = 1'b0;
        be_seen = '0; wd_seen = '0; we_seen = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if ((sel3 ? cs3 : cs0) === 1'b1) begin
                cs_seen++;
                be_seen = sel3 ? be3 : be0;
                wd_seen = sel3 ? swd3 : swd0;
                we_seen = sel3 ? we3 : we0;
            end
            if ((sel3 ? ack3 : ack0) === 1'b0) begin
                rd   = sel3 ? rdata3 : rdata0;
                er   = sel3 ? err3 : err0;
                done = 1'b1;
            end else begin
                busy++;
                @(posedge clk); #1;
            end
        end
        mreq0 = 1'b0; mreq3 = 1'b0;
        if (!done) busy = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mreq0 = 1'b0; mreq3 = 1'b0;
        dad = '0; write = 1'b0; size = 2'b10; wdata = '0;
        @(posedge clk); @(negedge clk);
        tests_run++; if (ack0 !== 1'b0) begin tests_failed++; $display("FAIL reset_ack_n got %b want 0", ack0); end
        tests_run++; if ({cs0, we0, be0, cs3, we3, be3} !== 12'h000) begin tests_failed++; $display("FAIL reset_sram_strobes got %h want 000", {cs0, we0, be0, cs3, we3, be3}); end
        tests_run++; if ({err0, err3} !== 2'b00) begin tests_failed++; $display("FAIL reset_err got %b want 00", {err0, err3}); end
        tests_run++; if (rdata0 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 00000000", rdata0); end
        tests_run++; if ({addr0, swd0} !== '0) begin tests_failed++; $display("FAIL reset_sram_addr_wdata got %h/%h want 0/0", addr0, swd0); end
        mreq0 = 1'b1; #1;
        tests_run++; if (ack0 !== 1'b1) begin tests_failed++; $display("FAIL idle_ack_follows_mreq got %b want 1", ack0); end
        mreq0 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        issue(1'b0, 32'h14, 1'b0, 2'b10, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (b != 2) begin tests_failed++; $display("FAIL word_load_latency got %0d want 2", b); end
        tests_run++; if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_load_rdata got %h want deadbeef", rd); end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL word_load_err got %b want 0", er); end
        tests_run++; if (cs != 1 || be !== 4'b1111 || we !== 1'b0) begin tests_failed++; $display("FAIL word_load_sram got cs=%0d be=%b we=%b want 1/1111/0", cs, be, we); end
        tests_run++; if (rdata0 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL word_load_hold got %h want deadbeef", rdata0); end
    endtask

    task automatic test_byte_store_load();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        issue(1'b0, 32'h16, 1'b1, 2'b00, 32'h0000_00AB, b, rd, er, cs, be, wd, we);
        tests_run++; if (b != 2 || cs != 1 || we !== 1'b1) begin tests_failed++; $display("FAIL byte_store_access got lat=%0d cs=%0d we=%b want 2/1/1", b, cs, we); end
        tests_run++; if (be !== 4'b0100) begin tests_failed++; $display("FAIL byte_store_be got %b want 0100", be); end
        tests_run++; if (wd !== 32'hABAB_ABAB) begin tests_failed++; $display("FAIL byte_store_wdata got %h want abababab", wd); end
        tests_run++; if (rdata0 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL store_keeps_rdata got %h want deadbeef", rdata0); end
        tests_run++; if (mem[5] !== 32'hDEAB_BEEF) begin tests_failed++; $display("FAIL byte_store_mem got %h want deabbeef", mem[5]); end
        issue(1'b0, 32'h14, 1'b0, 2'b10, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (rd !== 32'hDEAB_BEEF) begin tests_failed++; $display("FAIL load_after_store got %h want deabbeef", rd); end
    endtask

    task automatic test_subword_load();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        issue(1'b1, 32'h16, 1'b0, 2'b01, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (b != 5) begin tests_failed++; $display("FAIL half_wait3_latency got %0d want 5", b); end
        tests_run++; if (rd !== 32'h0000_DEAB) begin tests_failed++; $display("FAIL half_wait3_rdata got %h want 0000deab", rd); end
        tests_run++; if (er !== 1'b0 || cs != 1) begin tests_failed++; $display("FAIL half_wait3_err_cs got err=%b cs=%0d want 0/1", er, cs); end
        issue(1'b0, 32'h17, 1'b0, 2'b00, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (rd !== 32'h0000_00DE) begin tests_failed++; $display("FAIL byte3_load_rdata got %h want 000000de", rd); end
    endtask

    task automatic test_misaligned();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        issue(1'b0, 32'h15, 1'b0, 2'b10, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (b != 1) begin tests_failed++; $display("FAIL misaligned_latency got %0d want 1", b); end
        tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL misaligned_err got %b want 1", er); end
        tests_run++; if (cs != 0) begin tests_failed++; $display("FAIL misaligned_cs got %0d want 0", cs); end
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL misaligned_rdata got %h want 00000000", rd); end
        @(negedge clk);
        tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL err_one_cycle got %b want 0", err0); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        issue(1'b0, 32'h0001_0000, 1'b1, 2'b10, 32'h5555_5555, b, rd, er, cs, be, wd, we);
        tests_run++; if (er !== 1'b1 || b != 1) begin tests_failed++; $display("FAIL out_of_range_err got err=%b lat=%0d want 1/1", er, b); end
        tests_run++; if (cs != 0) begin tests_failed++; $display("FAIL out_of_range_cs got %0d want 0", cs); end
    endtask

    task automatic test_reset_mid_access();
        int b, cs; logic [31:0] rd, wd; logic er, we; logic [3:0] be;
        dad = 32'h1C; write = 1'b1; size = 2'b10; wdata = 32'h1111_1111;
        mreq3 = 1'b1;
        @(posedge clk); #2; mreq3 = 1'b0;
        @(negedge clk);
        tests_run++; if (ack3 !== 1'b1) begin tests_failed++; $display("FAIL wait_state_busy got %b want 1", ack3); end
        #1 rst = 1'b1; #1;
        tests_run++; if ({ack3, cs3, err3} !== 3'b000 || rdata3 !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_outputs got ack=%b cs=%b err=%b rdata=%h want 0/0/0/0", ack3, cs3, err3, rdata3); end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        tests_run++; if (mem[7] !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL mid_reset_mem got %h want cafef00d", mem[7]); end
        issue(1'b1, 32'h1C, 1'b0, 2'b10, 32'h0, b, rd, er, cs, be, wd, we);
        tests_run++; if (b != 5 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin tests_failed++; $display("FAIL post_reset_load got lat=%0d rdata=%h err=%b want 5/cafef00d/0", b, rd, er); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store_load();
        test_subword_load();
        test_misaligned();
        test_out_of_range();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
